afifo_rd_unpack_w64_to_w32: RTL and testbench

Read-side consumer for the 64-bit, 128-deep async FIFO. Runs in the FIFO read-clock domain, pops 64-bit words, and emits them as two 32-bit beats on a valid/ready stream toward the chipset I/O path. Follows the FIFO read contract: rd_en is sampled on a clock edge, and dout is valid from the following cycle until the next rd_en.

---
 rtl/afifo_rd_unpack_w64_to_w32_pkg.sv | 15 +
 rtl/afifo_rd_unpack_w64_to_w32.sv | 93 +++++++++
 tb/tb_afifo_rd_unpack_w64_to_w32.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_rd_unpack_w64_to_w32_pkg.sv
// Shared types for the 64->32 async FIFO read-side unpacker.
// Holds the FSM state encoding and the data widths.
package afifo_rd_unpack_w64_to_w32_pkg;

  localparam int IN_W  = 64;
  localparam int OUT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FIRST,
    S_SECOND
  } state_t;

endpackage

// File: rtl/afifo_rd_unpack_w64_to_w32.sv
// Pops 64-bit FIFO words and emits them as two 32-bit valid/ready beats.
// Define AFIFO_UNPACK_PREFETCH_EN to pop the next word during FIRST.
module afifo_rd_unpack_w64_to_w32
  import afifo_rd_unpack_w64_to_w32_pkg::*;
#(
  parameter bit LO_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [IN_W-1:0]  fifo_dout,
  output logic             fifo_rd_en,
  output logic             out_val,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_rdy,
  output logic             busy
);

  state_t          r_state;
  state_t          w_nxt;
  logic [IN_W-1:0] r_hold;
  logic            w_have_next;
  logic            w_pop_idle;
  logic            w_pop_sec;
  logic            w_pop_pre;
  logic            w_load;
  logic            w_acc2;
  logic            w_sel_hi;

  assign w_acc2     = (r_state == S_SECOND) && out_rdy;
  assign w_pop_idle = (r_state == S_IDLE) && !fifo_empty;
  assign w_pop_sec  = w_acc2 && !fifo_empty && !w_have_next;

`ifdef AFIFO_UNPACK_PREFETCH_EN
  logic r_have_next;

  assign w_pop_pre   = (r_state == S_FIRST) && out_rdy
                       && !fifo_empty && !r_have_next;
  assign w_have_next = r_have_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_have_next <= 1'b0;
    end else if (w_pop_pre) begin
      r_have_next <= 1'b1;
    end else if (w_acc2) begin
      r_have_next <= 1'b0;
    end
  end
`else
  assign w_pop_pre   = 1'b0;
  assign w_have_next = 1'b0;
`endif

  assign fifo_rd_en = w_pop_idle | w_pop_sec | w_pop_pre;

  // The FIFO's registered dout is valid in WAIT, or in SECOND after a prefetch.
  assign w_load = (r_state == S_WAIT) || (w_acc2 && w_have_next);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!fifo_empty) w_nxt = S_WAIT;
      S_WAIT:   w_nxt = S_FIRST;
      S_FIRST:  if (out_rdy) w_nxt = S_SECOND;
      S_SECOND: begin
        if (out_rdy) begin
          if (w_have_next)      w_nxt = S_FIRST;
          else if (!fifo_empty) w_nxt = S_WAIT;
          else                  w_nxt = S_IDLE;
        end
      end
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_load) r_hold <= fifo_dout;
    end
  end

  assign w_sel_hi = ((r_state == S_SECOND) == LO_FIRST);
  assign out_val  = (r_state == S_FIRST) || (r_state == S_SECOND);
  assign out_data = w_sel_hi ? r_hold[IN_W-1:OUT_W]
                             : r_hold[OUT_W-1:0];
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_afifo_rd_unpack_w64_to_w32.sv
// Bench for the 64->32 unpacker: FIFO model plus beat-queue scoreboard.
// Two instances (LO_FIRST=1 and 0) share one FIFO model and out_rdy.
module tb_afifo_rd_unpack_w64_to_w32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fifo_empty;
  logic [63:0] fifo_dout = '0;
  logic        out_rdy = 1'b0;
  logic        rd_en1, rd_en0;
  logic        val1, val0;
  logic        busy1, busy0;
  logic [31:0] data1, data0;

  logic [63:0] mem [0:127];
  int unsigned wr_p = 0;
  int unsigned rd_p = 0;
  int unsigned pops = 0;
  int unsigned n_busy = 0;
  int unsigned n_val = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp1[$];
  logic [31:0] exp0[$];

  always #5 clk = ~clk;

  assign fifo_empty = (wr_p == rd_p);

  afifo_rd_unpack_w64_to_w32 #(.LO_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(rd_en1), .out_val(val1),
    .out_data(data1), .out_rdy(out_rdy), .busy(busy1)
  );

  afifo_rd_unpack_w64_to_w32 #(.LO_FIRST(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(rd_en0), .out_val(val0),
    .out_data(data0), .out_rdy(out_rdy), .busy(busy0)
  );

  // FIFO model: registered dout, updated on a pop.
  always @(posedge clk) begin
    if (rd_en1 && (wr_p != rd_p)) begin
      fifo_dout <= mem[rd_p % 128];
      rd_p      <= rd_p + 1;
      pops      <= pops + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] w);
    mem[wr_p % 128] = w;
    wr_p = wr_p + 1;
    exp1.push_back(w[31:0]);
    exp1.push_back(w[63:32]);
    exp0.push_back(w[63:32]);
    exp0.push_back(w[31:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_val(input string tag);
    int n = 0;
    @(negedge clk);
    while (!val1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, val1, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy1 || !fifo_empty) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy1, 0);
    tick();
  endtask

  // Scoreboard monitor: every valid beat must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy1) n_busy <= n_busy + 1;
      if (val1) n_val <= n_val + 1;
      if (rd_en1 || rd_en0) chk("rd_en_while_empty", fifo_empty, 0);
      if (val1) begin
        if (exp1.size() == 0) chk("spurious_beat1", val1, 0);
        else begin
          chk("beat_lo_first", data1, exp1[0]);
          if (out_rdy) void'(exp1.pop_front());
        end
      end
      if (val0) begin
        if (exp0.size() == 0) chk("spurious_beat0", val0, 0);
        else begin
          chk("beat_hi_first", data0, exp0[0]);
          if (out_rdy) void'(exp0.pop_front());
        end
      end
    end
  end

  initial begin
    int unsigned p0, nb, nv;
    logic [63:0] wa, wb;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_val", val1, 0);
    chk("rst_rd_en", rd_en1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_data", data1, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single word, first-beat latency, empty at SECOND
    out_rdy = 1'b1;
    p0 = pops;
    push(64'hDEADBEEF_01234567);
    @(negedge clk);
    chk("t2_rd_en", rd_en1, 1);
    tick();
    @(negedge clk);
    chk("t2_wait_no_val", val1, 0);
    tick();
    @(negedge clk);
    chk("t2_first_val", val1, 1);
    chk("t2_first_lo", data1, 32'h01234567);
    chk("t2_first_hi0", data0, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    chk("t2_second_hi", data1, 32'hDEADBEEF);
    chk("t5_no_pop_empty", rd_en1, 0);
    tick();
    @(negedge clk);
    chk("t5_idle_busy", busy1, 0);
    chk("t2_one_pop", pops - p0, 1);
    tick();

    // Reversed beat order
    push(64'hAAAA0000_5555FFFF);
    wait_val("t6_val");
    chk("t6_first", data0, 32'hAAAA0000);
    @(negedge clk);
    chk("t6_second", data0, 32'h5555FFFF);
    wait_idle("t6_idle");

    // Backpressure in FIRST with a second word waiting
    out_rdy = 1'b0;
    wa = 64'h11112222_33334444;
    wb = 64'h55556666_77778888;
    push(wa);
    push(wb);
    wait_val("t3_val");
    p0 = pops;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stable", data1, wa[31:0]);
      chk("t3_no_pop", rd_en1, 0);
    end
    @(posedge clk);
    #1 out_rdy = 1'b1;
    wait_idle("t3_idle");
    chk("t3_pops", pops - p0, 1);

    // Stream of four words
    nb = n_busy;
    nv = n_val;
    p0 = pops;
    for (int i = 0; i < 4; i++) push({$urandom, $urandom});
    wait_idle("t4_idle");
`ifdef AFIFO_UNPACK_PREFETCH_EN
    chk("t4_busy_cycles", n_busy - nb, 9);
`else
    chk("t4_busy_cycles", n_busy - nb, 12);
`endif
    chk("t4_val_cycles", n_val - nv, 8);
    chk("t4_pops", pops - p0, 4);

    // Reset mid-FIRST
    out_rdy = 1'b0;
    push(64'hCAFEF00D_BAADC0DE);
    wait_val("t1_val");
    #2 rst_n = 1'b0;
    #1;
    chk("t1_val_async", val1, 0);
    chk("t1_rd_en_async", rd_en1, 0);
    chk("t1_busy_async", busy1, 0);
    chk("t1_data_async", data1, 0);
    exp1.delete();
    exp0.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_post_no_pop", rd_en1, 0);
      chk("t1_post_idle", busy1, 0);
    end
    tick();

    // Randomized traffic and stalls
    for (int i = 0; i < 500; i++) begin
      tick();
      out_rdy = ($urandom % 4) != 0;
      if (($urandom % 3) == 0 && (wr_p - rd_p) < 120)
        push({$urandom, $urandom});
    end
    tick();
    out_rdy = 1'b1;
    wait_idle("rand_idle");
    chk("sb_empty1", exp1.size(), 0);
    chk("sb_empty0", exp0.size(), 0);
    chk("pops_total", pops, wr_p);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
